// File: rtl/shot_buffer.sv
// rtl/shot_buffer.sv - pre/post-trigger capture ring with strobed single or looped readout
module shot_buffer #(
    parameter int WIDTH   = 16,
    parameter int DEPTH   = 1024,
    parameter int PRETRIG = 256,
    parameter int LOOP    = 0
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    tick_i,
    input  logic signed [WIDTH-1:0] signal_i,
    input  logic                    arm_i,
    input  logic                    trig_i,
    input  logic                    abort_i,
    input  logic                    rd_tick_i,
    output logic signed [WIDTH-1:0] signal_o,
    output logic                    valid_o,
    output logic                    done_o,
    output logic [2:0]              state_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] PRE_LEN  = CW'(PRETRIG);
    localparam logic [CW-1:0] POST_LEN = CW'(DEPTH - PRETRIG);
    localparam logic [CW-1:0] PASS_LEN = CW'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PRE   = 3'd1,
        S_ARMED = 3'd2,
        S_POST  = 3'd3,
        S_READ  = 3'd4
    } state_t;

    state_t                  state, state_d;
    logic [AW-1:0]           wp, wp_d, rp, rp_d;
    logic [CW-1:0]           cnt, cnt_d, cnt_inc;
    logic signed [WIDTH-1:0] sig_d;
    logic                    valid_d, done_d, we;

    logic signed [WIDTH-1:0] mem [DEPTH];

    always_comb begin
        state_d = state;
        wp_d    = wp;
        rp_d    = rp;
        cnt_d   = cnt;
        sig_d   = signal_o;
        valid_d = 1'b0;
        done_d  = 1'b0;
        we      = 1'b0;
        cnt_inc = cnt + 1'b1;
        if (abort_i) begin
            state_d = S_IDLE;
            sig_d   = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (arm_i) begin
                        wp_d    = '0;
                        cnt_d   = '0;
                        state_d = (PRETRIG == 0) ? S_ARMED : S_PRE;
                    end
                end
                S_PRE: begin
                    if (tick_i) begin
                        we    = 1'b1;
                        wp_d  = wp + 1'b1;
                        cnt_d = cnt_inc;
                        if (cnt_inc == PRE_LEN) state_d = S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (tick_i) begin
                        we   = 1'b1;
                        wp_d = wp + 1'b1;
                    end
                    if (trig_i) begin
                        state_d = S_POST;
                        cnt_d   = tick_i ? CW'(1) : '0;
                        // A coincident tick can already complete a one-sample post window
                        if (tick_i && POST_LEN == CW'(1)) begin
                            state_d = S_READ;
                            rp_d    = wp + 1'b1;
                            cnt_d   = '0;
                        end
                    end
                end
                S_POST: begin
                    if (tick_i) begin
                        we    = 1'b1;
                        wp_d  = wp + 1'b1;
                        cnt_d = cnt_inc;
                        // The slot after the final write holds the oldest retained sample
                        if (cnt_inc == POST_LEN) begin
                            state_d = S_READ;
                            rp_d    = wp + 1'b1;
                            cnt_d   = '0;
                        end
                    end
                end
                S_READ: begin
                    if (rd_tick_i) begin
                        sig_d   = mem[rp];
                        valid_d = 1'b1;
                        rp_d    = rp + 1'b1;
                        cnt_d   = cnt_inc;
                        if (cnt_inc == PASS_LEN) begin
                            done_d = 1'b1;
                            cnt_d  = '0;
                            if (LOOP == 0) state_d = S_IDLE;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= S_IDLE;
            wp       <= '0;
            rp       <= '0;
            cnt      <= '0;
            signal_o <= '0;
            valid_o  <= 1'b0;
            done_o   <= 1'b0;
        end else begin
            state    <= state_d;
            wp       <= wp_d;
            rp       <= rp_d;
            cnt      <= cnt_d;
            signal_o <= sig_d;
            valid_o  <= valid_d;
            done_o   <= done_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (we) mem[wp] <= signal_i;
    end

    assign state_o = state;

endmodule

// File: tb/tb_shot_buffer.sv
// tb/tb_shot_buffer.sv - three shot_buffer configurations driven in parallel against a history-queue model
module tb_shot_buffer;

    localparam int W = 16;
    localparam int D = 8;
    localparam int PT [3] = '{3, 0, 3};
    localparam int LP [3] = '{0, 0, 1};

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    logic tick = 1'b0, arm = 1'b0, trig = 1'b0, abort = 1'b0, rd = 1'b0;
    logic signed [W-1:0] sig_in = '0;

    logic signed [W-1:0] sig_o [3];
    logic                valid_o [3];
    logic                done_o [3];
    logic [2:0]          st_o [3];

    shot_buffer #(.WIDTH(W), .DEPTH(D), .PRETRIG(3), .LOOP(0)) u_a (
        .clk_i(clk), .rst_ni(rst_ni), .tick_i(tick), .signal_i(sig_in), .arm_i(arm),
        .trig_i(trig), .abort_i(abort), .rd_tick_i(rd), .signal_o(sig_o[0]),
        .valid_o(valid_o[0]), .done_o(done_o[0]), .state_o(st_o[0]));

    shot_buffer #(.WIDTH(W), .DEPTH(D), .PRETRIG(0), .LOOP(0)) u_b (
        .clk_i(clk), .rst_ni(rst_ni), .tick_i(tick), .signal_i(sig_in), .arm_i(arm),
        .trig_i(trig), .abort_i(abort), .rd_tick_i(rd), .signal_o(sig_o[1]),
        .valid_o(valid_o[1]), .done_o(done_o[1]), .state_o(st_o[1]));

    shot_buffer #(.WIDTH(W), .DEPTH(D), .PRETRIG(3), .LOOP(1)) u_c (
        .clk_i(clk), .rst_ni(rst_ni), .tick_i(tick), .signal_i(sig_in), .arm_i(arm),
        .trig_i(trig), .abort_i(abort), .rd_tick_i(rd), .signal_o(sig_o[2]),
        .valid_o(valid_o[2]), .done_o(done_o[2]), .state_o(st_o[2]));

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Model: every written sample is appended to a history; a finished capture is its last D entries
    int m_st [3];
    int hist [3][0:255];
    int hn [3];
    int npre [3];
    int npost [3];
    int cap [3][0:D-1];
    int k [3];
    int e_sig [3];
    int e_val [3];
    int e_done [3];

    int rec [3][0:63];
    int rn [3];
    int dn [3];

    task automatic lit(input string nm, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s @%0t: got %0d, want %0d", nm, $time, got, want);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_st[i] = 0; hn[i] = 0; k[i] = 0; npre[i] = 0; npost[i] = 0;
            e_sig[i] = 0; e_val[i] = 0; e_done[i] = 0;
        end
    endtask

    task automatic push(input int i);
        if (hn[i] < 256) hist[i][hn[i]] = int'(sig_in);
        hn[i]++;
    endtask

    task automatic close_capture(input int i);
        if (npost[i] == D - PT[i]) begin
            for (int j = 0; j < D; j++) cap[i][j] = hist[i][hn[i] - D + j];
            k[i] = 0;
            m_st[i] = 4;
        end
    endtask

    task automatic model_update();
        for (int i = 0; i < 3; i++) begin
            e_val[i] = 0;
            e_done[i] = 0;
            if (abort) begin
                m_st[i] = 0;
                e_sig[i] = 0;
            end else begin
                case (m_st[i])
                    0: if (arm) begin
                        hn[i] = 0; npre[i] = 0;
                        m_st[i] = (PT[i] == 0) ? 2 : 1;
                    end
                    1: if (tick) begin
                        push(i); npre[i]++;
                        if (npre[i] == PT[i]) m_st[i] = 2;
                    end
                    2: begin
                        if (tick) push(i);
                        if (trig) begin
                            m_st[i] = 3;
                            npost[i] = tick ? 1 : 0;
                            close_capture(i);
                        end
                    end
                    3: if (tick) begin
                        push(i); npost[i]++;
                        close_capture(i);
                    end
                    4: if (rd) begin
                        e_sig[i] = cap[i][k[i] % D];
                        e_val[i] = 1;
                        k[i]++;
                        if (k[i] % D == 0) begin
                            e_done[i] = 1;
                            if (LP[i] == 0) m_st[i] = 0;
                        end
                    end
                    default: m_st[i] = 0;
                endcase
            end
        end
    endtask

    task automatic step(input bit a, input bit tg, input bit tk, input bit r, input bit ab, input int s);
        arm = a; trig = tg; tick = tk; rd = r; abort = ab; sig_in = W'(s);
        @(posedge clk);
        model_update();
        #2;
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic clear_rec();
        for (int i = 0; i < 3; i++) begin rn[i] = 0; dn[i] = 0; end
    endtask

    // Abort, arm, nine ramp ticks, trigger (coincident with tick 10 or one cycle early), ramp to base+17
    task automatic capture(input int base, input bit early);
        step(0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0);
        for (int n = 1; n <= 9; n++) step(0, 0, 1, 0, 0, base + n);
        if (early) begin
            step(0, 1, 0, 0, 0, 0);
            step(0, 0, 1, 0, 0, base + 10);
        end else begin
            step(0, 1, 1, 0, 0, base + 10);
        end
        for (int n = 11; n <= 17; n++) step(0, 0, 1, 0, 0, base + n);
        idle(2);
    endtask

    // Strobes carry a coincident tick with a junk sample to show READ/IDLE never write it
    task automatic readout(input int nr, input int gap);
        for (int r = 0; r < nr; r++) begin
            step(0, 0, 1, 1, 0, 999);
            idle(gap);
        end
        idle(2);
    endtask

    task automatic chk_seq(input string nm, input int i, input int n, input int first, input int per);
        lit({nm, " count"}, rn[i], n);
        for (int j = 0; j < n && j < rn[i]; j++) lit({nm, " sample"}, rec[i][j], first + (j % per));
    endtask

    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                lit($sformatf("u%0d signal_o", i), int'(sig_o[i]), e_sig[i]);
                lit($sformatf("u%0d valid_o", i), int'(valid_o[i]), e_val[i]);
                lit($sformatf("u%0d done_o", i), int'(done_o[i]), e_done[i]);
                lit($sformatf("u%0d state_o", i), int'(st_o[i]), m_st[i]);
                if (valid_o[i] === 1'b1 && rn[i] < 64) begin
                    rec[i][rn[i]] = int'(sig_o[i]);
                    rn[i]++;
                end
                if (done_o[i] === 1'b1) dn[i]++;
            end
        end
    end

    initial begin
        model_reset();
        clear_rec();
        #1;
        for (int i = 0; i < 3; i++) begin
            lit("reset state_o", int'(st_o[i]), 0);
            lit("reset signal_o", int'(sig_o[i]), 0);
            lit("reset valid_o", int'(valid_o[i]), 0);
            lit("reset done_o", int'(done_o[i]), 0);
        end
        @(posedge clk); @(posedge clk); #2;
        rst_ni = 1'b1;
        idle(2);

        // Coincident trigger; looped instance reads 20 strobes
        capture(0, 0);
        clear_rec();
        readout(20, 1);
        chk_seq("t1 a", 0, 8, 7, 8);
        lit("t1 a done count", dn[0], 1);
        lit("t1 a idle after pass", int'(st_o[0]), 0);
        lit("t1 a holds last", int'(sig_o[0]), 14);
        chk_seq("t1 b", 1, 8, 10, 8);
        chk_seq("t1 c", 2, 20, 7, 8);
        lit("t1 c done count", dn[2], 2);
        lit("t1 c stays read", int'(st_o[2]), 4);

        // Trigger one cycle before tick 10, back-to-back strobes
        capture(0, 1);
        clear_rec();
        readout(8, 0);
        chk_seq("t2 a", 0, 8, 7, 8);
        chk_seq("t2 b", 1, 8, 10, 8);

        // Zero pre-trigger: trigger right after arm
        step(0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        for (int n = 1; n <= 8; n++) step(0, 0, 1, 0, 0, n);
        idle(2);
        clear_rec();
        readout(8, 1);
        chk_seq("t3 b", 1, 8, 1, 8);
        lit("t3 b done count", dn[1], 1);
        lit("t3 a untriggered reads nothing", rn[0], 0);

        // Abort in POST with negative samples, then a fresh capture
        step(0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0);
        for (int n = 1; n <= 9; n++) step(0, 0, 1, 0, 0, -50 + n);
        step(0, 1, 1, 0, 0, -40);
        step(0, 0, 1, 0, 0, -39);
        lit("t4 a in post", int'(st_o[0]), 3);
        step(0, 0, 1, 1, 1, -38);
        lit("t4 a abort state", int'(st_o[0]), 0);
        lit("t4 a abort signal", int'(sig_o[0]), 0);
        lit("t4 a abort valid", int'(valid_o[0]), 0);
        capture(0, 0);
        clear_rec();
        readout(8, 1);
        chk_seq("t4 a", 0, 8, 7, 8);

        // Asynchronous reset mid-readout
        capture(0, 0);
        clear_rec();
        for (int r = 0; r < 3; r++) begin
            step(0, 0, 0, 1, 0, 0);
            idle(1);
        end
        chk_seq("t5 a before reset", 0, 3, 7, 8);
        rst_ni = 1'b0;
        model_reset();
        #1;
        for (int i = 0; i < 3; i++) begin
            lit("t5 async state_o", int'(st_o[i]), 0);
            lit("t5 async signal_o", int'(sig_o[i]), 0);
            lit("t5 async valid_o", int'(valid_o[i]), 0);
            lit("t5 async done_o", int'(done_o[i]), 0);
        end
        @(posedge clk); #2;
        rst_ni = 1'b1;
        clear_rec();
        readout(4, 1);
        for (int i = 0; i < 3; i++) lit("t5 no valid after reset", rn[i], 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
